fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its queue.
package fetch_unit_pkg;

  localparam int unsigned DefaultDepth   = 4;
  localparam logic [15:0] DefaultResetPc = 16'h0000;

  // One queued instruction: byte PC of the word and the fetched word itself.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue for the fetch unit: power-of-two FIFO with flush and an
// occupancy output used by the fetch credit logic.
module fetch_fifo import fetch_unit_pkg::*; #(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [31:0]     push_entry,
  input  logic            pop,
  output logic [31:0]     head,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  // Flush discards both the queue contents and any same-cycle push/pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; left uninitialised, occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to a 2-cycle memory,
// tracks in-flight reads, and buffers responses in a small queue. Issue is
// credit-limited so a response always finds a free queue slot.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter logic [15:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:1] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [15:0]     pc_q;
  logic [15:0]     pc_d;
  logic [15:0]     pc1_q;
  logic [15:0]     pc2_q;
  logic            v1_q;
  logic            v2_q;
  logic [CntW-1:0] count;
  logic [CntW:0]   in_use;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  // Slots already committed: queued entries plus reads still in the pipe.
  assign in_use = {1'b0, count} + (CntW + 1)'(v1_q) + (CntW + 1)'(v2_q);
  assign issue  = !redirect_valid && (32'(in_use) < DEPTH);

  assign mem_raddr = pc_q[15:1];

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push       = v2_q && !redirect_valid;
  assign push_entry = '{pc: pc2_q, data: mem_rdata};
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  // Next fetch address: redirect target, else advance on issue.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[15:1], 1'b0};
    end else if (issue) begin
      pc_d = pc_q + 16'd2;
    end
  end

  // PC and two-stage in-flight tracker matching the memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= {RESET_PC[15:1], 1'b0};
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      pc1_q <= '0;
      pc2_q <= '0;
    end else begin
      pc_q  <= pc_d;
      v1_q  <= issue;
      v2_q  <= v1_q && !redirect_valid;
      pc1_q <= pc_q;
      pc2_q <= pc1_q;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// ready/redirect/reset traffic, checked by a stream-level scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:1] mem_raddr;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;
  int deliv_count = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  // Memory contents: words 0..3 are 1111..4444, the rest a fixed scramble.
  function automatic logic [15:0] mem_word(input logic [14:0] a);
    logic [15:0] w;
    if (a < 15'd4) w = 16'h1111 * ({1'b0, a} + 16'd1);
    else           w = {a[6:0], a[14:7], 1'b1} ^ 16'h5A3C;
    return w;
  endfunction

  // Memory read port: data for the address of cycle t appears in cycle t+2.
  logic [15:0] rd_stage;
  always @(posedge clk) begin
    rd_stage  <= mem_word(mem_raddr);
    mem_rdata <= rd_stage;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: after a flush, delivery is the straight-line word stream
  // starting at the target, wrapping mod 2^16.
  logic [31:0] exp_q[$];
  logic [15:0] exp_next_pc;

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_next_pc, mem_word(exp_next_pc[15:1])});
      exp_next_pc = exp_next_pc + 16'd2;
    end
  endfunction

  function automatic void model_flush(input logic [15:0] target);
    exp_q.delete();
    exp_next_pc = {target[15:1], 1'b0};
    refill();
  endfunction

  // Monitor: compares deliveries and the post-flush timing rules.
  int          since_flush = 1000;
  logic        ready_run   = 1'b0;
  logic [15:0] flush_tgt   = 16'h0000;
  logic [31:0] exp_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (!inst_ready) ready_run = 1'b0;
      if (since_flush >= 1 && since_flush <= 3)
        chk("no_valid_after_flush", {31'd0, inst_valid}, 32'd0);
      if (since_flush == 1)
        chk("raddr_after_flush", {17'd0, mem_raddr}, {17'd0, flush_tgt[15:1]});
      if (ready_run && since_flush >= 4 && since_flush < 1000)
        chk("steady_valid", {31'd0, inst_valid}, 32'd1);
      if (!redirect_valid && inst_valid && inst_ready) begin
        deliv_count++;
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", {inst_pc, inst_data}, 32'hFFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          chk("delivered", {inst_pc, inst_data}, exp_e);
        end
        refill();
      end
    end
    if (reset || redirect_valid) begin
      since_flush = 1;
      flush_tgt   = reset ? RESET_PC : redirect_pc;
      ready_run   = 1'b1;
    end else if (since_flush < 1000) begin
      since_flush++;
    end
  end

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic rdy);
    reset          = 1'b1;
    inst_ready     = rdy;
    redirect_valid = 1'b0;
    model_flush(RESET_PC);
    repeat (n) cycle_start();
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    model_flush(t);
    cycle_start();
    redirect_valid = 1'b0;
  endtask

  int          d0;
  logic [15:0] tgt;
  int          r;

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b1;

    // Reset release with ready high: first word visible three cycles in.
    do_reset(3, 1'b1);
    for (int c = 0; c < 6; c++) begin
      sample();
      if (c == 0) chk("raddr_first", {17'd0, mem_raddr}, {17'd0, RESET_PC[15:1]});
      chk("release_valid", {31'd0, inst_valid}, (c < 3) ? 32'd0 : 32'd1);
      if (c == 3) chk("release_w0", {inst_pc, inst_data}, 32'h0000_1111);
      if (c == 4) chk("release_w1", {inst_pc, inst_data}, 32'h0002_2222);
      if (c == 5) chk("release_w2", {inst_pc, inst_data}, 32'h0004_3333);
      cycle_start();
    end

    // Consumer stalled: credit caps issue at DEPTH words.
    do_reset(2, 1'b0);
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c == 10 || c == 19) chk("stall_raddr", {17'd0, mem_raddr}, 32'h0000_0004);
      if (c == 19) chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      cycle_start();
    end
    inst_ready = 1'b1;
    d0 = deliv_count;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c == 4) chk("drain_four", deliv_count - d0, 32'd4);
      cycle_start();
    end
    sample();
    chk("drain_continuous", deliv_count - d0, 32'd8);
    chk("issue_resumed", {17'd0, mem_raddr}, 32'h0000_000B);
    cycle_start();

    // Redirect with two entries queued and two reads in flight.
    do_reset(2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      sample();
      if (c == 3) chk("queued_before_redirect", {31'd0, inst_valid}, 32'd1);
      cycle_start();
    end
    inst_ready = 1'b1;
    do_redirect(16'h0101);
    sample();
    chk("redirect_empty", {31'd0, inst_valid}, 32'd0);
    chk("redirect_raddr", {17'd0, mem_raddr}, 32'h0000_0080);
    cycle_start();
    repeat (8) cycle_start();

    // Redirect in steady state: response and dequeue collide with it.
    tgt = 16'($urandom);
    do_redirect(tgt);
    repeat (8) cycle_start();

    // Wrap past the top of the address space.
    do_redirect(16'hFFFC);
    for (int k = 1; k <= 7; k++) begin
      sample();
      if (k >= 4) chk("wrap_pc", {16'd0, inst_pc}, {16'd0, 16'hFFFC + 16'(2 * (k - 4))});
      cycle_start();
    end

    // Back-to-back redirects: only the second target is fetched.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h7000;
    model_flush(16'h7000);
    cycle_start();
    do_redirect(16'h2469);
    for (int k = 1; k <= 4; k++) begin
      sample();
      if (k == 4) chk("b2b_target", {15'd0, inst_valid, inst_pc}, {15'd0, 1'b1, 16'h2468});
      cycle_start();
    end

    // Reset mid-stream with the queue full; overrides redirect and ready.
    inst_ready = 1'b0;
    repeat (10) cycle_start();
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    inst_ready     = 1'b1;
    model_flush(RESET_PC);
    cycle_start();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    sample();
    chk("reset_mid_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_mid_raddr", {17'd0, mem_raddr}, {17'd0, RESET_PC[15:1]});
    cycle_start();
    repeat (10) cycle_start();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      inst_ready = ($urandom_range(0, 3) != 0);
      if (r < 3) begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        model_flush(RESET_PC);
      end else if (r < 50) begin
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = (r < 10) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                  : 16'($urandom);
        model_flush(redirect_pc);
      end else begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
      end
      cycle_start();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    repeat (10) cycle_start();

    chk("enough_deliveries", {31'd0, deliv_count > 500}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
